// File: rtl/load_store_unit.sv
// load_store_unit
//   Accepts one load/store request at a time and routes it to data memory,
//   to the UART transmit register, or to the hardware counter. Misaligned,
//   reserved-size and out-of-window requests are rejected without touching
//   memory or the UART.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_op[3:0]              bit3 store, bit2 unsigned load, bits1:0 size
//   req_addr[31:0]           byte address
//   req_wdata[31:0]          store data
//   resp_valid               one-cycle response strobe
//   resp_rdata[31:0]         load result (0 for stores and errors)
//   resp_err                 request was rejected
//   mem_req/mem_gnt          data-memory request handshake
//   mem_we[3:0]              byte-lane write enables (0 for loads)
//   mem_addr[ADDR_W-1:0]     word address relative to DATA_BASE
//   mem_wdata[31:0]          store data replicated across lanes
//   mem_rvalid/mem_rdata     load return data
//   uart_valid/uart_ready    UART transmit handshake, uart_data[7:0] byte
//   hc_value[31:0]           free-running hardware counter
module load_store_unit #(
  parameter logic [31:0] DATA_BASE = 32'h0001_0000,
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] UART_ADDR = 32'h0002_0000,
  parameter logic [31:0] HC_ADDR   = 32'h0002_0004
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              uart_valid,
  output logic [7:0]        uart_data,
  input  logic              uart_ready,
  input  logic [31:0]       hc_value
);

  typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, UART, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Decode of the incoming request, used only at acceptance.
  logic        req_store, req_is_uart, req_is_hc, req_in_range, req_error;
  logic [31:0] req_off;

  always_comb begin
    req_store    = req_op[3];
    req_is_uart  = (req_addr == UART_ADDR);
    req_is_hc    = (req_addr == HC_ADDR);
    req_off      = req_addr - DATA_BASE;
    // Unsigned offset test also rejects addresses below DATA_BASE (wrap).
    req_in_range = ((req_off >> (ADDR_W + 2)) == 32'd0);
    req_error    = (req_op[1:0] == 2'b11)
                 | ((req_op[1:0] == 2'b01) & req_addr[0])
                 | ((req_op[1:0] == 2'b10) & (req_addr[1:0] != 2'b00))
                 | (!req_is_uart & !req_is_hc & !req_in_range)
                 | (req_is_hc & !req_store & (req_op[1:0] != 2'b10));
  end

  // Load data extraction: shift the addressed lane down to bit 0. Word
  // loads are always aligned, so the shift is zero and the word passes.
  logic [31:0] lane_data, load_ext;

  always_comb begin
    lane_data = mem_rdata >> {addr_q[1:0], 3'b000};
    case (op_q[1:0])
      2'b00:   load_ext = op_q[2] ? {24'd0, lane_data[7:0]}
                                  : {{24{lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_ext = op_q[2] ? {16'd0, lane_data[15:0]}
                                  : {{16{lane_data[15]}}, lane_data[15:0]};
      default: load_ext = lane_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and Moore outputs. Every output is zero unless the current
  // state owns it.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 4'd0;
    mem_addr   = '0;
    mem_wdata  = 32'd0;
    uart_valid = 1'b0;
    uart_data  = 8'd0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          if (req_error) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (req_is_uart) begin
            state_d = req_store ? UART : RESP;
          end else if (req_is_hc) begin
            // Counter is sampled here so the response reflects acceptance time.
            if (!req_store) rdata_d = hc_value;
            state_d = RESP;
          end else begin
            state_d = MEM_REQ;
          end
        end
      end

      MEM_REQ: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_W'((addr_q - DATA_BASE) >> 2);
        if (op_q[3]) begin
          case (op_q[1:0])
            2'b00:   begin
              mem_we    = 4'b0001 << addr_q[1:0];
              mem_wdata = {4{wdata_q[7:0]}};
            end
            2'b01:   begin
              mem_we    = 4'b0011 << addr_q[1:0];
              mem_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
              mem_we    = 4'b1111;
              mem_wdata = wdata_q;
            end
          endcase
        end
        if (mem_gnt) state_d = op_q[3] ? RESP : MEM_WAIT;
      end

      // Only reached after the grant cycle, so a same-cycle rvalid is never seen.
      MEM_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = load_ext;
          state_d = RESP;
        end
      end

      UART: begin
        uart_valid = 1'b1;
        uart_data  = wdata_q[7:0];
        if (uart_ready) state_d = RESP;
      end

      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Drives directed and random load/store requests into load_store_unit and
//   compares every cycle against a byte-addressed memory model and a
//   request classifier that work from addresses and sizes directly.
module tb_load_store_unit;

  localparam logic [31:0] DATA_BASE = 32'h0001_0000;
  localparam int          ADDR_W    = 14;
  localparam logic [31:0] UART_ADDR = 32'h0002_0000;
  localparam logic [31:0] HC_ADDR   = 32'h0002_0004;
  localparam int          MEM_BYTES = 4 << ADDR_W;

  localparam logic [3:0] OP_LB = 4'b0000, OP_LH = 4'b0001, OP_LW = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_SB = 4'b1000, OP_SW = 4'b1010;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_req;
  logic              mem_gnt;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              uart_valid;
  logic [7:0]        uart_data;
  logic              uart_ready;
  logic [31:0]       hc_value;

  int check_count = 0;
  int error_count = 0;

  logic [7:0] mem_bytes [MEM_BYTES];

  typedef enum int {K_ERR, K_UART_ST, K_UART_LD, K_HC_ST, K_HC_LD, K_MEM_ST, K_MEM_LD} kind_e;

  always #5 clk = ~clk;

  load_store_unit #(
    .DATA_BASE(DATA_BASE), .ADDR_W(ADDR_W), .UART_ADDR(UART_ADDR), .HC_ADDR(HC_ADDR)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .uart_valid(uart_valid), .uart_data(uart_data), .uart_ready(uart_ready),
    .hc_value(hc_value)
  );

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  // What kind of access a request is, from address arithmetic alone.
  function automatic kind_e classify(input logic [3:0] op, input logic [31:0] addr);
    int unsigned size_bytes;
    logic [31:0] off;
    if (op[1:0] == 2'b11) return K_ERR;
    size_bytes = 1 << op[1:0];
    if ((addr % size_bytes) != 0) return K_ERR;
    if (addr == UART_ADDR) return op[3] ? K_UART_ST : K_UART_LD;
    if (addr == HC_ADDR) begin
      if (op[3]) return K_HC_ST;
      return (size_bytes == 4) ? K_HC_LD : K_ERR;
    end
    off = addr - DATA_BASE;
    if (off >= MEM_BYTES) return K_ERR;
    return op[3] ? K_MEM_ST : K_MEM_LD;
  endfunction

  // Little-endian read of 1/2/4 bytes from the model, then extension.
  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr);
    int unsigned off, n;
    logic [31:0] v;
    off = addr - DATA_BASE;
    n = 1 << op[1:0];
    v = 32'd0;
    for (int i = 0; i < int'(n); i++) v = v | (32'(mem_bytes[off + i]) << (8 * i));
    if (!op[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    int unsigned base;
    base = (addr - DATA_BASE) & ~32'd3;
    return {mem_bytes[base + 3], mem_bytes[base + 2], mem_bytes[base + 1], mem_bytes[base]};
  endfunction

  // One complete transaction. Entered and left on a falling edge; the
  // responders are driven by cycle number relative to acceptance.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input int gnt_delay, input int rv_delay, input int uart_delay,
                               input logic [31:0] hc, output logic [31:0] rdata_obs);
    kind_e       kind;
    int          resp_at, n;
    int unsigned off;
    logic [31:0] exp_rdata, exp_wdata;
    logic [3:0]  exp_we;
    logic        exp_err, is_mem, is_load, exp_mem_req, exp_uart;

    kind      = classify(op, addr);
    is_mem    = (kind == K_MEM_ST) || (kind == K_MEM_LD);
    is_load   = (kind == K_MEM_LD);
    exp_err   = (kind == K_ERR);
    exp_rdata = 32'd0;
    off       = addr - DATA_BASE;
    n         = 1 << op[1:0];
    exp_we    = 4'd0;
    exp_wdata = 32'd0;
    rdata_obs = 32'd0;
    if (kind == K_MEM_ST) begin
      for (int i = 0; i < n; i++) exp_we[(off % 4) + i] = 1'b1;
      for (int j = 0; j < 4; j++) exp_wdata[8 * j +: 8] = wdata[8 * (j % n) +: 8];
    end
    case (kind)
      K_UART_ST: resp_at = 2 + uart_delay;
      K_MEM_ST:  resp_at = 2 + gnt_delay;
      K_MEM_LD:  begin resp_at = 3 + gnt_delay + rv_delay; exp_rdata = model_load(op, addr); end
      K_HC_LD:   begin resp_at = 1; exp_rdata = hc; end
      default:   resp_at = 1;
    endcase

    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; hc_value = hc;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; uart_ready = 1'b0;
    checkOutput("req_ready_before_accept", req_ready, 1'b1);
    @(posedge clk); #1;
    // Scramble inputs after acceptance: the captured copies must be used.
    req_valid = 1'b0; req_op = 4'($urandom); req_addr = $urandom;
    req_wdata = $urandom; hc_value = $urandom;

    for (int k = 1; k <= resp_at + 1; k++) begin
      @(negedge clk);
      exp_mem_req = is_mem && (k <= 1 + gnt_delay);
      exp_uart    = (kind == K_UART_ST) && (k <= 1 + uart_delay);
      checkOutput("mem_req", mem_req, exp_mem_req);
      checkOutput("uart_valid", uart_valid, exp_uart);
      checkOutput("resp_valid", resp_valid, k == resp_at);
      checkOutput("req_ready", req_ready, k == resp_at + 1);
      if (exp_mem_req) begin
        checkOutput("mem_addr", 32'(mem_addr), off >> 2);
        checkOutput("mem_we", mem_we, exp_we);
        checkOutput("mem_wdata", mem_wdata, exp_wdata);
      end else begin
        checkOutput("mem_we_idle", mem_we, 4'd0);
      end
      if (exp_uart) checkOutput("uart_data", uart_data, wdata[7:0]);
      if (k == resp_at) begin
        checkOutput("resp_rdata", resp_rdata, exp_rdata);
        checkOutput("resp_err", resp_err, exp_err);
        rdata_obs = resp_rdata;
      end else begin
        checkOutput("resp_rdata_idle", resp_rdata, 32'd0);
      end

      mem_gnt    = exp_mem_req ? (k == 1 + gnt_delay) : 1'($urandom % 2);
      uart_ready = exp_uart ? (k == 1 + uart_delay) : 1'($urandom % 2);
      mem_rdata  = $urandom;
      if (is_load && k == 1 + gnt_delay) begin
        mem_rvalid = 1'b1;
      end else if (is_load && k >= 2 + gnt_delay && k < resp_at) begin
        mem_rvalid = (k == resp_at - 1);
        if (k == resp_at - 1) mem_rdata = model_word(addr);
      end else begin
        mem_rvalid = 1'($urandom % 2);
      end
    end

    if (kind == K_MEM_ST)
      for (int i = 0; i < n; i++) mem_bytes[off + i] = wdata[8 * i +: 8];
  endtask

  logic [31:0] got;
  logic [31:0] rand_addr;
  logic [3:0]  rand_op;
  int          sel;

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem_bytes[i] = 8'($urandom);
    rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'd0; req_wdata = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; uart_ready = 1'b0; hc_value = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", req_ready, 1'b1);
    checkOutput("reset_resp_valid", resp_valid, 1'b0);
    checkOutput("reset_mem_req", mem_req, 1'b0);
    checkOutput("reset_uart_valid", uart_valid, 1'b0);
    checkOutput("reset_mem_we", mem_we, 4'd0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store with immediate grant.
    applyStimulus(OP_SW, 32'h0001_0008, 32'hDEAD_BEEF, 0, 0, 0, 32'd0, got);
    // Byte store to the top lane, then signed and unsigned byte loads of it.
    applyStimulus(OP_SB, 32'h0001_0003, 32'h0000_00A5, 1, 0, 0, 32'd0, got);
    applyStimulus(OP_LB, 32'h0001_0003, 32'd0, 0, 3, 0, 32'd0, got);
    checkOutput("lb_sign_extended", got, 32'hFFFF_FFA5);
    applyStimulus(OP_LBU, 32'h0001_0003, 32'd0, 2, 1, 0, 32'd0, got);
    checkOutput("lbu_zero_extended", got, 32'h0000_00A5);
    // Rejected requests: misaligned half, below base, just past the window.
    // The first word past the window is the UART register at these
    // addresses, so the next non-MMIO word stands in for it.
    applyStimulus(OP_LH, 32'h0001_0001, 32'd0, 0, 0, 0, 32'd0, got);
    applyStimulus(OP_LW, 32'h0000_FFFC, 32'd0, 0, 0, 0, 32'd0, got);
    applyStimulus(OP_SW, 32'h0002_0008, 32'h1234_5678, 0, 0, 0, 32'd0, got);
    // UART byte held through five not-ready cycles.
    applyStimulus(OP_SB, UART_ADDR, 32'h0000_0041, 0, 0, 5, 32'd0, got);
    // Counter read.
    applyStimulus(OP_LW, HC_ADDR, 32'd0, 0, 0, 0, 32'd1000, got);
    checkOutput("hc_read", got, 32'd1000);

    // Reset while waiting for load data: aborted with no response.
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0001_0010; mem_gnt = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0;
    checkOutput("abort_wait_mem_req", mem_req, 1'b0);
    checkOutput("abort_wait_busy", req_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    checkOutput("abort_wait_ready", req_ready, 1'b1);
    checkOutput("abort_wait_resp", resp_valid, 1'b0);
    @(negedge clk); mem_rvalid = 1'b0;
    checkOutput("abort_wait_no_resp", resp_valid, 1'b0);

    // Reset while the UART byte is pending: uart_valid drops at the same edge.
    req_valid = 1'b1; req_op = OP_SB; req_addr = UART_ADDR; req_wdata = 32'h55; uart_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_uart_valid", uart_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checkOutput("abort_uart_dropped", uart_valid, 1'b0);
    checkOutput("abort_uart_ready", req_ready, 1'b1);
    @(negedge clk);
    checkOutput("abort_uart_no_resp", resp_valid, 1'b0);

    // Random traffic weighted toward a small memory region so loads hit stores.
    for (int t = 0; t < 300; t++) begin
      rand_op = 4'($urandom);
      sel = $urandom_range(0, 9);
      if (sel <= 5)      rand_addr = DATA_BASE + ($urandom % 64);
      else if (sel == 6) rand_addr = DATA_BASE + MEM_BYTES - 4 + ($urandom % 4);
      else if (sel == 7) rand_addr = UART_ADDR + ($urandom % 2);
      else if (sel == 8) rand_addr = HC_ADDR;
      else rand_addr = ($urandom % 2) ? DATA_BASE - 1 - ($urandom % 8)
                                      : DATA_BASE + MEM_BYTES + ($urandom % 32);
      applyStimulus(rand_op, rand_addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
